// File: rtl/cholesky_array_div.sv
// rtl/cholesky_array_div.sv - six-lane iterative restoring divider array for the Cholesky stage
//
// Purpose: divides LANES signed fixed-point dividends by one common signed divisor,
//   producing trunc((dividend * 2^FRAC) / divisor) per lane, saturated symmetrically
//   to +/-(2^(W-1)-1). One quotient bit per clock, all lanes in lockstep.
//   Latency from accepted start edge to done = W+FRAC+1 clocks.
// Ports:
//   clk           clock, all state on posedge
//   rst           asynchronous active-high reset
//   start         request, sampled only while idle
//   dividends     [LANES-1:0][W-1:0] signed numerators, captured at start
//   divisor       [W-1:0] signed common denominator, captured at start
//   busy          high from accepted start until the done cycle
//   done          one-cycle pulse, quotients valid
//   quotients     [LANES-1:0][W-1:0] signed results, held until next completion
//   div_by_zero   (only with CHOLESKY_ARRAY_DIV_DBZ_EN) captured divisor was zero
// Configuration macro: CHOLESKY_ARRAY_DIV_DBZ_EN adds the div_by_zero output.

module cholesky_array_div #(
  parameter int LANES = 6,
  parameter int W     = 27,
  parameter int FRAC  = 13
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [LANES-1:0][W-1:0]  dividends,
  input  logic [W-1:0]             divisor,
  output logic                     busy,
  output logic                     done,
  output logic [LANES-1:0][W-1:0]  quotients
`ifdef CHOLESKY_ARRAY_DIV_DBZ_EN
  ,
  output logic                     div_by_zero
`endif
);

  localparam int ITER = W + FRAC;
  localparam int NW   = W + FRAC;
  localparam int CW   = $clog2(ITER);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DIV  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};

  logic [1:0]                 state;
  logic [CW-1:0]              cnt;
  // num_q starts as |dividend|<<FRAC; its MSBs feed the remainder while quotient
  // bits enter at the LSB, so after ITER shifts it holds the full quotient.
  logic [LANES-1:0][NW-1:0]   num_q;
  logic [LANES-1:0][W-1:0]    rem_q;
  logic [W-1:0]               dabs_q;
  logic [LANES-1:0]           neg_q;
  logic [LANES-1:0]           nz_q;

  logic [W-1:0]               dsr_abs;
  logic [LANES-1:0][W-1:0]    dvd_abs;
  logic [LANES-1:0][W:0]      r_shift;
  logic [LANES-1:0]           ge;
  logic [LANES-1:0][W-1:0]    rem_nx;
  logic [LANES-1:0][NW-1:0]   num_nx;
  logic [LANES-1:0]           sat;
  logic [LANES-1:0][W-1:0]    mag;
  logic [LANES-1:0][W-1:0]    q_fix;

  always_comb begin
    dsr_abs = divisor[W-1] ? (~divisor + 1'b1) : divisor;
    dvd_abs = '0;
    r_shift = '0;
    ge      = '0;
    rem_nx  = '0;
    num_nx  = '0;
    sat     = '0;
    mag     = '0;
    q_fix   = '0;
    for (int i = 0; i < LANES; i++) begin
      // W-bit unsigned magnitude holds |-2^(W-1)| exactly.
      dvd_abs[i] = dividends[i][W-1] ? (~dividends[i] + 1'b1) : dividends[i];

      r_shift[i] = {rem_q[i], num_q[i][NW-1]};
      ge[i]      = (r_shift[i] >= {1'b0, dabs_q});
      // When ge holds the true difference is below |divisor|, so W bits suffice.
      rem_nx[i]  = ge[i] ? (r_shift[i][W-1:0] - dabs_q) : r_shift[i][W-1:0];
      num_nx[i]  = {num_q[i][NW-2:0], ge[i]};

      sat[i]     = |num_q[i][NW-1:W-1];
      mag[i]     = sat[i] ? MAXV : {1'b0, num_q[i][W-2:0]};
      // A zero divisor yields an all-ones quotient, which saturates; a zero
      // dividend must still come out as zero in that case.
      if (!nz_q[i]) begin
        q_fix[i] = '0;
      end else if (neg_q[i]) begin
        q_fix[i] = ~mag[i] + 1'b1;
      end else begin
        q_fix[i] = mag[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      num_q     <= '0;
      rem_q     <= '0;
      dabs_q    <= '0;
      neg_q     <= '0;
      nz_q      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotients <= '0;
`ifdef CHOLESKY_ARRAY_DIV_DBZ_EN
      div_by_zero <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            for (int i = 0; i < LANES; i++) begin
              num_q[i] <= {dvd_abs[i], {FRAC{1'b0}}};
              neg_q[i] <= dividends[i][W-1] ^ divisor[W-1];
              nz_q[i]  <= |dividends[i];
            end
            rem_q  <= '0;
            dabs_q <= dsr_abs;
            cnt    <= CW'(ITER - 1);
            busy   <= 1'b1;
            state  <= S_DIV;
          end
        end
        S_DIV: begin
          num_q <= num_nx;
          rem_q <= rem_nx;
          if (cnt == '0) begin
            state <= S_FIX;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_FIX: begin
          quotients <= q_fix;
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
`ifdef CHOLESKY_ARRAY_DIV_DBZ_EN
          div_by_zero <= (dabs_q == '0);
`endif
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cholesky_array_div.sv
// tb/tb_cholesky_array_div.sv - self-checking bench for cholesky_array_div

module tb_cholesky_array_div;

  localparam int LANES = 6;
  localparam int W     = 27;
  localparam int FRAC  = 13;
  localparam int LAT   = W + FRAC + 1;
  localparam longint MAXV = (longint'(1) <<< (W - 1)) - 1;

  typedef struct packed {
    logic [LANES-1:0][W-1:0] a;
    logic [W-1:0]            b;
    logic [LANES-1:0][W-1:0] e;
  } vec_t;

  logic                    clk;
  logic                    rst;
  logic                    start;
  logic [LANES-1:0][W-1:0] dividends;
  logic [W-1:0]            divisor;
  logic                    busy;
  logic                    done;
  logic [LANES-1:0][W-1:0] quotients;
`ifdef CHOLESKY_ARRAY_DIV_DBZ_EN
  logic                    div_by_zero;
`endif

  cholesky_array_div #(.LANES(LANES), .W(W), .FRAC(FRAC)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividends (dividends),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotients (quotients)
`ifdef CHOLESKY_ARRAY_DIV_DBZ_EN
    ,
    .div_by_zero (div_by_zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [LANES-1:0][W-1:0] exp_q[$];
  vec_t tbl[11];

  task automatic chk(input string name, input longint got, input longint want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  function automatic vec_t mk(input int a0, input int a1, input int a2, input int a3,
                              input int a4, input int a5, input int b,
                              input int e0, input int e1, input int e2, input int e3,
                              input int e4, input int e5);
    vec_t v;
    v.a[0] = W'(a0); v.a[1] = W'(a1); v.a[2] = W'(a2);
    v.a[3] = W'(a3); v.a[4] = W'(a4); v.a[5] = W'(a5);
    v.b    = W'(b);
    v.e[0] = W'(e0); v.e[1] = W'(e1); v.e[2] = W'(e2);
    v.e[3] = W'(e3); v.e[4] = W'(e4); v.e[5] = W'(e5);
    return v;
  endfunction

  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa;
    longint sb;
    longint q;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sb == 0) begin
      q = (sa > 0) ? MAXV : ((sa < 0) ? -MAXV : 0);
    end else begin
      q = (sa * (longint'(1) <<< FRAC)) / sb;
      if (q > MAXV) q = MAXV;
      if (q < -MAXV) q = -MAXV;
    end
    return W'(q);
  endfunction

  // Waits for done with a cycle budget, scrambling inputs mid-run and optionally
  // re-pulsing start at cycle 'poke'. Counts cycles and busy-high samples.
  task automatic wait_done(input int poke, output int n, output int bcnt);
    n = 0;
    bcnt = 0;
    while (!done && n < 100) begin
      if (busy) bcnt++;
      if (n == 3) begin
        for (int l = 0; l < LANES; l++) dividends[l] = W'($urandom);
        divisor = W'($urandom);
      end
      start = (n == poke);
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic dbz_want);
    logic [LANES-1:0][W-1:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      for (int l = 0; l < LANES; l++)
        chk($sformatf("%s_lane%0d", tag, l), longint'($signed(quotients[l])),
            longint'($signed(e[l])));
    end
`ifdef CHOLESKY_ARRAY_DIV_DBZ_EN
    chk({tag, "_dbz"}, longint'(div_by_zero), longint'(dbz_want));
`else
    if (dbz_want && !dbz_want) chk({tag, "_dbz"}, 0, 1);
`endif
  endtask

  task automatic launch(input vec_t v);
    dividends = v.a;
    divisor   = v.b;
    start     = 1'b1;
    exp_q.push_back(v.e);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_one(input vec_t v, input string tag);
    int n;
    int bcnt;
    launch(v);
    chk({tag, "_busy_set"}, longint'(busy), 1);
    wait_done(-1, n, bcnt);
    chk({tag, "_latency"}, n, LAT);
    chk({tag, "_busy_cycles"}, bcnt, LAT);
    chk({tag, "_busy_at_done"}, longint'(busy), 0);
    check_result(tag, v.b == '0);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, longint'(done), 0);
  endtask

  initial begin
    int n;
    int bcnt;
    int ndone;
    logic [LANES-1:0][W-1:0] held;

    tbl[0] = mk(49152, 49152, 49152, 49152, 49152, 49152, 16384,
                24576, 24576, 24576, 24576, 24576, 24576);
    tbl[1] = mk(1, -1, 0, 3, -3, 7, 3,
                2730, -2730, 0, 8192, -8192, 19114);
    tbl[2] = mk(-1, 1, -4, 4, 2, -2, 4,
                -2048, 2048, -8192, 8192, 4096, -4096);
    tbl[3] = mk(1, -1, 8, 0, -8, 3, -4,
                -2048, 2048, -16384, 0, 16384, -6144);
    tbl[4] = mk(-6, 6, 1, -1, 0, -3, -2,
                24576, -24576, -4096, 4096, 0, 12288);
    tbl[5] = mk(67108863, -67108864, 0, 1, -1, 100, 1,
                67108863, -67108863, 0, 8192, -8192, 819200);
    tbl[6] = mk(5, -5, 0, 1, -1, 67108863, 0,
                67108863, -67108863, 0, 67108863, -67108863, 67108863);
    for (int k = 7; k < 11; k++) begin
      for (int l = 0; l < LANES; l++) tbl[k].a[l] = W'($urandom) >> $urandom_range(0, 20);
      if (k[0]) tbl[k].b = W'($urandom);
      else      tbl[k].b = W'($urandom_range(1, 1 << 20));
      if (k == 8) tbl[k].b = W'(-$signed({1'b0, tbl[k].b[W-2:0]}));
      for (int l = 0; l < LANES; l++) tbl[k].e[l] = model(tbl[k].a[l], tbl[k].b);
    end

    rst = 1'b1;
    start = 1'b0;
    dividends = '0;
    divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", longint'(busy), 0);
    chk("reset_done", longint'(done), 0);
    chk("reset_quot", longint'(quotients != '0), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) run_one(tbl[i], $sformatf("v%0d", i));

    // start re-pulsed mid-run is ignored; start in the done cycle is accepted
    launch(tbl[0]);
    wait_done(10, n, bcnt);
    chk("repulse_latency", n, LAT);
    check_result("repulse", 1'b0);
    held = quotients;
    launch(tbl[1]);
    chk("back2back_done_drop", longint'(done), 0);
    chk("back2back_busy", longint'(busy), 1);
    chk("back2back_held", longint'(quotients == held), 1);
    wait_done(-1, n, bcnt);
    chk("back2back_latency", n, LAT);
    check_result("back2back", 1'b0);
    ndone = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("no_queued_start", ndone, 0);

    // reset mid-run aborts immediately and yields no done
    launch(tbl[2]);
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_busy", longint'(busy), 0);
    chk("abort_done", longint'(done), 0);
    chk("abort_quot", longint'(quotients != '0), 0);
    void'(exp_q.pop_back());
    @(posedge clk); #1;
    rst = 1'b0;
    ndone = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    chk("abort_idle", longint'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
